// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
// Read hits are answered combinationally. Read misses refill a whole line
// word by word over a request/acknowledge port. Every store is forwarded to
// the backing memory, and the cached copy is updated only when the store hits.
module data_cache #(
    parameter int DATA_WIDTH  = 32,
    parameter int LINES       = 64,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int INDEX_W  = $clog2(LINES);
    localparam int OFFSET_W = $clog2(BLOCK_WORDS);
    localparam int IDX_LSB  = 2 + OFFSET_W;
    localparam int TAG_LSB  = 2 + OFFSET_W + INDEX_W;
    localparam int TAG_W    = DATA_WIDTH - TAG_LSB;

    localparam logic [OFFSET_W-1:0]   LAST_WORD = OFFSET_W'(BLOCK_WORDS - 1);
    localparam logic [OFFSET_W-1:0]   CNT_ONE   = OFFSET_W'(1);
    localparam logic [DATA_WIDTH-1:0] WORD_MASK = ~DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] LINE_MASK = ~DATA_WIDTH'(4 * BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REFILL,
        ST_WRITE,
        ST_WDONE
    } state_t;

    state_t state_q, state_d;

    // Latched request context and word counter.
    logic [OFFSET_W-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic                  hit_q, hit_d;
    logic [LINES-1:0]      valid_q, valid_d;

    // Registered memory-side outputs.
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    // Tag and data arrays with their write ports.
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES][BLOCK_WORDS];
    logic                  tag_we;
    logic                  data_we;
    logic [OFFSET_W-1:0]   data_wword;
    logic [DATA_WIDTH-1:0] data_wdata;

    // Field split of the live CPU address and of the latched address.
    logic [DATA_WIDTH-1:0] a_word, a_line;
    logic [TAG_W-1:0]      req_tag, lat_tag;
    logic [INDEX_W-1:0]    req_idx, lat_idx;
    logic [OFFSET_W-1:0]   req_word, lat_word;
    logic                  hit;

    assign a_word   = a & WORD_MASK;
    assign a_line   = a & LINE_MASK;
    assign req_tag  = a[TAG_LSB +: TAG_W];
    assign req_idx  = a[IDX_LSB +: INDEX_W];
    assign req_word = a[2 +: OFFSET_W];
    assign lat_tag  = addr_q[TAG_LSB +: TAG_W];
    assign lat_idx  = addr_q[IDX_LSB +: INDEX_W];
    assign lat_word = addr_q[2 +: OFFSET_W];

    assign hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign rd  = data_mem[req_idx][req_word];

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: flops are written with <= so every register samples the
        // pre-edge values, independent of statement order between blocks.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a store takes priority over a simultaneous load.
    always_comb begin
        // NOTE: every comb output gets a default first so no path through
        // the case leaves it unassigned, which would infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (we)            state_d = ST_WRITE;
                else if (re && !hit) state_d = ST_REFILL;
            end
            ST_REFILL: if (mem_ack && cnt_q == LAST_WORD) state_d = ST_IDLE;
            ST_WRITE:  if (mem_ack) state_d = ST_WRITE == state_q ? ST_WDONE : state_q;
            ST_WDONE:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Pipeline stall: high on a load miss or store in IDLE and throughout the
    // memory transaction; low in WDONE so the store retires.
    always_comb begin
        stall = 1'b0;
        unique case (state_q)
            ST_IDLE:   stall = we || (re && !hit);
            ST_REFILL: stall = 1'b1;
            ST_WRITE:  stall = 1'b1;
            ST_WDONE:  stall = 1'b0;
            default:   stall = 1'b0;
        endcase
    end

    // Datapath next values: request latching, refill sequencing, array writes.
    always_comb begin
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        hit_d       = hit_q;
        valid_d     = valid_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tag_we      = 1'b0;
        data_we     = 1'b0;
        data_wword  = lat_word;
        data_wdata  = mem_wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (we) begin
                    addr_d      = a_word;
                    hit_d       = hit;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = a_word;
                    mem_wdata_d = wd;
                end else if (re && !hit) begin
                    // The line is invalid until its last word arrives.
                    addr_d           = a_line;
                    cnt_d            = '0;
                    valid_d[req_idx] = 1'b0;
                    mem_req_d        = 1'b1;
                    mem_we_d         = 1'b0;
                    mem_addr_d       = a_line;
                end
            end
            ST_REFILL: begin
                if (mem_ack) begin
                    data_we    = 1'b1;
                    data_wword = cnt_q;
                    data_wdata = mem_rdata;
                    cnt_d      = cnt_q + CNT_ONE;
                    mem_addr_d = addr_q;
                    mem_addr_d[2 +: OFFSET_W] = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_WORD) begin
                        tag_we           = 1'b1;
                        valid_d[lat_idx] = 1'b1;
                        mem_req_d        = 1'b0;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    // A write miss leaves the arrays untouched.
                    data_we   = hit_q;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers, including the memory-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            hit_q       <= 1'b0;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            hit_q       <= hit_d;
            valid_q     <= valid_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Tag and data array writes.
    always_ff @(posedge clk) begin
        // NOTE: the arrays have no reset; the valid bits alone decide whether
        // their contents mean anything, which keeps them mappable to RAM.
        if (tag_we)  tag_mem[lat_idx] <= lat_tag;
        if (data_we) data_mem[lat_idx][data_wword] <= data_wdata;
    end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: table-driven directed vectors, a reset-during-refill sequence
// and randomized loads/stores checked against a line-level reference model.
module tb_data_cache;

    localparam int DW    = 32;
    localparam int LINES = 64;
    localparam int BW    = 4;
    localparam int LINE_BYTES = 4 * BW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] a = '0, wd = '0;
    logic          we = 1'b0, re = 1'b0;
    logic [DW-1:0] rd;
    logic          stall;
    logic          mem_req, mem_we;
    logic [DW-1:0] mem_addr, mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    data_cache #(.DATA_WIDTH(DW), .LINES(LINES), .BLOCK_WORDS(BW)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .wd(wd), .we(we), .re(re),
        .rd(rd), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- backing memory responder ----------------
    typedef struct {
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    txn_t          txn_q[$];
    logic [DW-1:0] bmem [logic [DW-1:0]];
    int            lat = 1;
    int            wait_cnt = 0;

    // Acks the current request on its lat-th cycle; unwritten words read as their address.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else begin
            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
            if (mem_req) begin
                if (wait_cnt >= lat - 1) begin
                    mem_ack = 1'b1;
                    txn_q.push_back('{mem_we, mem_addr, mem_wdata});
                    if (mem_we) bmem[mem_addr] = mem_wdata;
                    else        mem_rdata = bmem.exists(mem_addr) ? bmem[mem_addr] : mem_addr;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    bit            m_valid [LINES];
    int unsigned   m_tag   [LINES];
    logic [DW-1:0] ref_mem [logic [DW-1:0]];

    function automatic logic [DW-1:0] ref_read(input logic [DW-1:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : wa;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_op(input logic op_we, input logic op_re, input logic [DW-1:0] op_a,
                            input logic [DW-1:0] op_wd, input int op_lat,
                            output int exp_stall, output int exp_nreq, output logic [DW-1:0] exp_rd);
        int            idx;
        int unsigned   tg;
        logic [DW-1:0] wa;
        idx    = int'((op_a / LINE_BYTES) % LINES);
        tg     = op_a / (LINE_BYTES * LINES);
        wa     = op_a & ~32'h3;
        exp_rd = ref_read(wa);
        if (op_we) begin
            exp_stall   = 1 + op_lat;
            exp_nreq    = 1;
            ref_mem[wa] = op_wd;
        end else if (op_re) begin
            if (m_valid[idx] && m_tag[idx] == tg) begin
                exp_stall = 0;
                exp_nreq  = 0;
            end else begin
                exp_stall    = 1 + BW * op_lat;
                exp_nreq     = BW;
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
            end
        end else begin
            exp_stall = 0;
            exp_nreq  = 0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one CPU request, holds it while stalled and checks the outcome.
    task automatic run_op(input string name, input logic op_we, input logic op_re,
                          input logic [DW-1:0] op_a, input logic [DW-1:0] op_wd, input int op_lat,
                          input int exp_stall, input int exp_nreq, input logic [DW-1:0] exp_rd);
        int            cycles, start, n;
        logic          pending;
        logic [DW-1:0] h_addr, h_wd, got_rd;
        @(posedge clk); #1;
        lat = op_lat; a = op_a; wd = op_wd; we = op_we; re = op_re;
        start = txn_q.size(); cycles = 0; pending = 1'b0; h_addr = '0; h_wd = '0;
        forever begin
            @(negedge clk); #1;
            if (!stall) break;
            cycles++;
            if (mem_req) begin
                if (pending) begin
                    check({name, " addr held"}, mem_addr, h_addr);
                    check({name, " wdata held"}, mem_wdata, h_wd);
                end
                h_addr  = mem_addr;
                h_wd    = mem_wdata;
                pending = !mem_ack;
            end
            if (cycles > 200) begin
                total++; bad++;
                $display("FAIL %s timeout: stall still high after %0d cycles", name, cycles);
                break;
            end
        end
        got_rd = rd;
        check({name, " stall cycles"}, DW'(cycles), DW'(exp_stall));
        check({name, " mem_req idle"}, DW'(mem_req), '0);
        n = txn_q.size() - start;
        check({name, " txn count"}, DW'(n), DW'(exp_nreq));
        if (n == exp_nreq) begin
            for (int k = 0; k < n; k++) begin
                if (op_we) begin
                    check({name, " wr we"}, DW'(txn_q[start+k].we), DW'(1));
                    check({name, " wr addr"}, txn_q[start+k].addr, op_a & ~32'h3);
                    check({name, " wr data"}, txn_q[start+k].wdata, op_wd);
                end else begin
                    check({name, " rf we"}, DW'(txn_q[start+k].we), DW'(0));
                    check({name, " rf addr"}, txn_q[start+k].addr, (op_a & ~32'hF) + DW'(4 * k));
                end
            end
        end
        if (op_re && !op_we) check({name, " rd"}, got_rd, exp_rd);
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic          we;
        logic          re;
        logic [DW-1:0] a;
        logic [DW-1:0] wd;
        int            lat;
        int            exp_stall;
        int            exp_nreq;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #1_000_000;
        $display("FAIL global timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int            ms, mn, n;
        logic [DW-1:0] mr;
        logic          r_we, r_re;
        logic [DW-1:0] r_a, r_wd;
        int            r_lat;

        vecs[0]  = '{1'b0, 1'b1, 32'h100,  32'h0,        1, 5, 4, 32'h100};
        vecs[1]  = '{1'b0, 1'b1, 32'h108,  32'h0,        1, 0, 0, 32'h108};
        vecs[2]  = '{1'b1, 1'b0, 32'h104,  32'hDEADBEEF, 1, 2, 1, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'h104,  32'h0,        1, 0, 0, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 1'b0, 32'h2000, 32'h12345678, 1, 2, 1, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 32'h2000, 32'h0,        1, 5, 4, 32'h12345678};
        vecs[6]  = '{1'b0, 1'b1, 32'h100,  32'h0,        1, 0, 0, 32'h100};
        vecs[7]  = '{1'b0, 1'b1, 32'h500,  32'h0,        1, 5, 4, 32'h500};
        vecs[8]  = '{1'b0, 1'b1, 32'h100,  32'h0,        1, 5, 4, 32'h100};
        vecs[9]  = '{1'b1, 1'b1, 32'h100,  32'hCAFEF00D, 3, 4, 1, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 32'h100,  32'h0,        1, 0, 0, 32'hCAFEF00D};
        vecs[11] = '{1'b0, 1'b1, 32'h104,  32'h0,        1, 0, 0, 32'hDEADBEEF};

        // Reset state.
        model_clear();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset stall", DW'(stall), '0);
        check("reset mem_req", DW'(mem_req), '0);
        check("reset mem_we", DW'(mem_we), '0);
        check("reset mem_addr", mem_addr, '0);
        check("reset mem_wdata", mem_wdata, '0);
        #1 rst_n = 1'b1;

        // Directed table; the model tracks along so later phases stay consistent.
        for (int i = 0; i < 12; i++) begin
            model_op(vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].wd, vecs[i].lat, ms, mn, mr);
            run_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].wd,
                   vecs[i].lat, vecs[i].exp_stall, vecs[i].exp_nreq, vecs[i].exp_rd);
        end

        // Reset while the refill of line 0x300 is on its third word.
        @(posedge clk); #1;
        lat = 1; a = 32'h300; re = 1'b1;
        n = 0;
        begin
            int start;
            start = txn_q.size();
            while (txn_q.size() - start < 3 && n < 50) begin
                @(negedge clk); #1;
                n++;
            end
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL midreset timeout: third refill ack never seen");
        end
        check("midreset mem_addr", mem_addr, 32'h308);
        check("midreset mem_req before", DW'(mem_req), DW'(1));
        #1 rst_n = 1'b0;
        #1;
        check("midreset mem_req async drop", DW'(mem_req), '0);
        check("midreset mem_addr cleared", mem_addr, '0);
        re = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        model_clear();
        model_op(1'b0, 1'b1, 32'h300, 32'h0, 1, ms, mn, mr);
        run_op("reload 0x300", 1'b0, 1'b1, 32'h300, 32'h0, 1, 5, 4, 32'h300);
        model_op(1'b0, 1'b1, 32'h100, 32'h0, 1, ms, mn, mr);
        run_op("after reset 0x100", 1'b0, 1'b1, 32'h100, 32'h0, 1, 5, 4, 32'hCAFEF00D);

        // Randomized traffic over a small address pool to mix hits, misses and conflicts.
        for (int i = 0; i < 300; i++) begin
            r_a   = (DW'($urandom_range(0, 2)) << 10) | (DW'($urandom_range(0, 3)) << 4) |
                    (DW'($urandom_range(0, 3)) << 2) | DW'($urandom_range(0, 3));
            r_wd  = $urandom;
            r_lat = $urandom_range(1, 3);
            n     = $urandom_range(0, 9);
            r_we  = (n < 3);
            r_re  = (n != 9) && (n != 3) ? 1'b1 : (n == 3);
            if (n == 9) r_re = 1'b0;
            model_op(r_we, r_re, r_a, r_wd, r_lat, ms, mn, mr);
            run_op($sformatf("rnd%0d", i), r_we, r_re, r_a, r_wd, r_lat, ms, mn, mr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
